// File: rtl/palette_lut_if.sv
// palette_lut_if: controller req/ack port and pixel lookup port of palette_lut.
// Optional alpha output is present when PALETTE_ALPHA_EN is defined.
interface palette_lut_if #(
  parameter int unsigned LAYER_BITS = 5,
  parameter int unsigned COLOR_BITS = 5,
  parameter int unsigned CH_W       = 16,
  parameter int unsigned OUT_W      = 8
);
  // controller side (port A)
  logic                  ctl_req;
  logic                  ctl_we;
  logic [LAYER_BITS-1:0] ctl_layer;
  logic [COLOR_BITS-1:0] ctl_color;
  logic [1:0]            ctl_ch;
  logic [CH_W-1:0]       ctl_wdata;
  logic                  ctl_ack;
  logic [CH_W-1:0]       ctl_rdata;

  // pixel pipeline side (port B)
  logic                  pix_valid_in;
  logic [LAYER_BITS-1:0] pix_layer;
  logic [COLOR_BITS-1:0] pix_color;
  logic                  pix_valid_out;
  logic [3*OUT_W-1:0]    pix_rgb;
  logic                  pix_found;
`ifdef PALETTE_ALPHA_EN
  logic [OUT_W-1:0]      pix_alpha;
`endif

  logic                  init_busy;

  modport master (
    output ctl_req, ctl_we, ctl_layer, ctl_color, ctl_ch, ctl_wdata,
    output pix_valid_in, pix_layer, pix_color,
    input  ctl_ack, ctl_rdata, pix_valid_out, pix_rgb, pix_found,
`ifdef PALETTE_ALPHA_EN
    input  pix_alpha,
`endif
    input  init_busy
  );

  modport slave (
    input  ctl_req, ctl_we, ctl_layer, ctl_color, ctl_ch, ctl_wdata,
    input  pix_valid_in, pix_layer, pix_color,
    output ctl_ack, ctl_rdata, pix_valid_out, pix_rgb, pix_found,
`ifdef PALETTE_ALPHA_EN
    output pix_alpha,
`endif
    output init_busy
  );
endinterface

// File: rtl/palette_lut.sv
// palette_lut: per-layer colour palette. Three channel RAMs (R,G,B), port A
// owned by a req/ack controller FSM, port B by a fixed 2-cycle lookup pipeline.
// After reset a hardware sweep clears every entry.
// Define PALETTE_ALPHA_EN to add a fourth (alpha) RAM on channel 3 and pix_alpha.
module palette_lut #(
  parameter int unsigned LAYER_BITS = 5,
  parameter int unsigned COLOR_BITS = 5,
  parameter int unsigned CH_W       = 16,
  parameter int unsigned OUT_W      = 8
) (
  input logic          clk,
  input logic          rst,
  palette_lut_if.slave bus
);

  localparam int unsigned ADDR_W = LAYER_BITS + COLOR_BITS;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
`ifdef PALETTE_ALPHA_EN
  localparam int unsigned NUM_CH = 4;
`else
  localparam int unsigned NUM_CH = 3;
`endif

  typedef enum logic [2:0] {INIT, IDLE, WRITE, READ, ACK} stateT;

  stateT             state, stateNext;
  logic [ADDR_W-1:0] sweepAddr, sweepAddrNext;
  logic              capture;

  // captured controller request
  logic [LAYER_BITS-1:0] capLayer;
  logic [COLOR_BITS-1:0] capColor;
  logic [1:0]            capCh;
  logic [CH_W-1:0]       capWdata;

  // port A write controls and read word
  logic [NUM_CH-1:0] ramWe;
  logic [ADDR_W-1:0] ramWAddr;
  logic [CH_W-1:0]   ramWData;
  logic [CH_W-1:0]   portAWord;

  // channel storage, one RAM per channel
  logic [CH_W-1:0] mem [NUM_CH][DEPTH];

  // pixel pipeline stage 1
  logic              s1Valid;
  logic              s1Opaque;
  logic [OUT_W-1:0]  pixMsb [NUM_CH];
`ifdef PALETTE_ALPHA_EN
  logic              pixAlphaNz;
`endif

  logic [ADDR_W-1:0] pixAddr;
  assign pixAddr = {bus.pix_layer, bus.pix_color};

  // controller state register and sweep address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      sweepAddr <= '0;
    end else begin
      state     <= stateNext;
      sweepAddr <= sweepAddrNext;
    end
  end

  // controller next-state and port A write controls
  always_comb begin
    stateNext     = state;
    sweepAddrNext = sweepAddr;
    capture       = 1'b0;
    ramWe         = '0;
    ramWAddr      = {capLayer, capColor};
    ramWData      = capWdata;
    unique case (state)
      INIT: begin
        ramWe         = '1;
        ramWAddr      = sweepAddr;
        ramWData      = '0;
        sweepAddrNext = sweepAddr + ADDR_W'(1);
        if (sweepAddr == ADDR_W'(DEPTH - 1)) stateNext = IDLE;
      end
      IDLE: begin
        if (bus.ctl_req) begin
          capture   = 1'b1;
          stateNext = bus.ctl_we ? WRITE : READ;
        end
      end
      WRITE: begin
        // colour 0 is transparent and never stored; channels without a RAM drop the write
        for (int c = 0; c < NUM_CH; c++) begin
          ramWe[c] = (capColor != '0) && (capCh == 2'(c));
        end
        stateNext = ACK;
      end
      READ:    stateNext = ACK;
      ACK:     stateNext = IDLE;
      default: stateNext = INIT;
    endcase
  end

  // capture the controller request in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      capLayer <= '0;
      capColor <= '0;
      capCh    <= '0;
      capWdata <= '0;
    end else if (capture) begin
      capLayer <= bus.ctl_layer;
      capColor <= bus.ctl_color;
      capCh    <= bus.ctl_ch;
      capWdata <= bus.ctl_wdata;
    end
  end

  // port A read mux; a channel without a RAM reads as 0
  always_comb begin
    portAWord = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (capCh == 2'(c)) portAWord = mem[c][{capLayer, capColor}];
    end
  end

  // controller outputs: ack pulse, read data, sweep status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ctl_ack   <= 1'b0;
      bus.ctl_rdata <= '0;
      bus.init_busy <= 1'b1;
    end else begin
      bus.ctl_ack   <= (state == WRITE) || (state == READ);
      bus.init_busy <= (stateNext == INIT);
      if (state == READ) bus.ctl_rdata <= portAWord;
    end
  end

  // RAM array: port A write, port B registered read (old data on collision)
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (ramWe[c]) mem[c][ramWAddr] <= ramWData;
      pixMsb[c] <= mem[c][pixAddr][CH_W-1 -: OUT_W];
    end
`ifdef PALETTE_ALPHA_EN
    pixAlphaNz <= (mem[3][pixAddr] != '0);
`endif
  end

  // pipeline stage 1: valid and transparency flag, lookups dropped during the sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid  <= 1'b0;
      s1Opaque <= 1'b0;
    end else begin
      s1Valid  <= bus.pix_valid_in && (state != INIT);
      s1Opaque <= (bus.pix_color != '0);
    end
  end

  // pipeline stage 2: result registers, held while no valid result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pix_valid_out <= 1'b0;
      bus.pix_rgb       <= '0;
      bus.pix_found     <= 1'b0;
`ifdef PALETTE_ALPHA_EN
      bus.pix_alpha     <= '0;
`endif
    end else begin
      bus.pix_valid_out <= s1Valid;
      if (s1Valid) begin
        bus.pix_rgb <= s1Opaque ? {pixMsb[0], pixMsb[1], pixMsb[2]} : '0;
`ifdef PALETTE_ALPHA_EN
        bus.pix_found <= s1Opaque && pixAlphaNz;
        bus.pix_alpha <= s1Opaque ? pixMsb[3] : '0;
`else
        bus.pix_found <= s1Opaque;
`endif
      end
    end
  end

endmodule
